// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D memory arbiter.
// Holds the default bus widths, the response-stage state encoding and the
// starvation counter width used by mem_arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_DATA_W   = 32;
    localparam int STARVE_CNT_W = 4;

    // Which requester (if any) gets read data in the next cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } resp_state_t;

endpackage

// File: rtl/mem_arb_sat_cnt.sv
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
// Ports: clk, rst_n (async active-low), inc (count enable), count (value).
// Latency: count reflects inc one clock later; no backpressure.
module mem_arb_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port async-read RAM between a fetch port (I, read-only)
// and a load/store port (D). Grants are combinational, read data returns
// registered one cycle after the grant; a losing requester simply holds req.
// Ports: i_* fetch port, d_* load/store port, mem_* RAM port, cnt_* perf counters.
// Optional feature: define MEM_ARB_PERF_EN to build the conflict/stall
// counters; otherwise cnt_conflict and cnt_stall_i are tied to zero.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [CNT_W-1:0]  cnt_conflict,
    output logic [CNT_W-1:0]  cnt_stall_i
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic                    force_i;
    resp_state_t             resp_state;

    // ------------------------------------------------------------------
    // Grant: D has priority unless I has lost LIMIT cycles in a row.
    // ------------------------------------------------------------------
    assign force_i = (starve_cnt == LIMIT);
    assign d_gnt   = d_req & ~force_i;
    assign i_gnt   = i_req & ~d_gnt;

    // RAM port follows the winner; with no grant it idles on the I address.
    assign mem_addr  = d_gnt ? d_addr : i_addr;
    // rst_n gating keeps a held store request from writing during reset.
    assign mem_we    = d_gnt & d_we & rst_n;
    assign mem_wdata = d_wdata;

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive I losses to D. An I grant or
    // I withdrawing its request restarts the count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!i_req || i_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + STARVE_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Response stage. The next state comes straight from this cycle's read
    // grant, so back-to-back reads stream with no bubble. rdata registers
    // only load on their own grant and otherwise hold.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_state <= IDLE;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            if (i_gnt) begin
                resp_state <= RESP_I;
                i_rdata    <= mem_rdata;
            end else if (d_gnt && !d_we) begin
                resp_state <= RESP_D;
                d_rdata    <= mem_rdata;
            end else begin
                resp_state <= IDLE;
            end
        end
    end

    assign i_rvalid = (resp_state == RESP_I);
    assign d_rvalid = (resp_state == RESP_D);

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef MEM_ARB_PERF_EN
    mem_arb_sat_cnt #(.W(CNT_W)) u_cnt_conflict (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (i_req & d_req),
        .count (cnt_conflict)
    );

    mem_arb_sat_cnt #(.W(CNT_W)) u_cnt_stall_i (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (i_req & ~i_gnt),
        .count (cnt_stall_i)
    );
`else
    assign cnt_conflict = '0;
    assign cnt_stall_i  = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic, all compared against a transaction-level reference model.
// The RAM itself lives here as an async-read / posedge-write array.
module tb_mem_arbiter;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int LIM  = 3;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_gnt, i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [CW-1:0] cnt_conflict, cnt_stall_i;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .cnt_conflict(cnt_conflict), .cnt_stall_i(cnt_stall_i)
    );

    // Physical RAM driven by the DUT's memory port.
    logic [DW-1:0] ram [0:1023];
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

    // Reference model state (transaction level).
    logic [DW-1:0] ref_mem [0:1023];
    int            losses;          // consecutive cycles I asked and D won
    bit            exp_i_rv, exp_d_rv;
    logic [DW-1:0] exp_i_rd, exp_d_rd;
    int            exp_conf, exp_stall;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        losses    = 0;
        exp_i_rv  = 1'b0;
        exp_d_rv  = 1'b0;
        exp_i_rd  = '0;
        exp_d_rd  = '0;
        exp_conf  = 0;
        exp_stall = 0;
    endtask

    // One clock with the currently driven inputs: check everything at the
    // negedge, advance the model, return at posedge+1 with the grants seen.
    task automatic cycle(output bit gi, output bit gd);
        bit ed, ei;
        @(negedge clk);
        ed = d_req && (losses < LIM);
        ei = i_req && !ed;
        check("d_gnt",    d_gnt,    ed);
        check("i_gnt",    i_gnt,    ei);
        check("mem_we",   mem_we,   ed && d_we);
        check("mem_addr", mem_addr, ed ? d_addr : i_addr);
        if (ed && d_we) check("mem_wdata", mem_wdata, d_wdata);
        check("i_rvalid", i_rvalid, exp_i_rv);
        check("d_rvalid", d_rvalid, exp_d_rv);
        check("i_rdata",  i_rdata,  exp_i_rd);
        check("d_rdata",  d_rdata,  exp_d_rd);
`ifdef MEM_ARB_PERF_EN
        check("cnt_conflict", cnt_conflict, exp_conf);
        check("cnt_stall_i",  cnt_stall_i,  exp_stall);
`else
        check("cnt_conflict", cnt_conflict, 0);
        check("cnt_stall_i",  cnt_stall_i,  0);
`endif
        // Advance the model by one transaction step.
        exp_i_rv = ei;
        exp_d_rv = ed && !d_we;
        if (ei) exp_i_rd = ref_mem[i_addr];
        if (ed && !d_we) exp_d_rd = ref_mem[d_addr];
        if (ed && d_we) ref_mem[d_addr] = d_wdata;
        if (i_req && ed) losses = (losses < LIM) ? losses + 1 : LIM;
        else             losses = 0;
        if (i_req && d_req && exp_conf < CMAX) exp_conf++;
        if (i_req && !ei && exp_stall < CMAX)  exp_stall++;
        gi = ei;
        gd = ed;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    initial begin
        bit gi, gd;
        for (int k = 0; k < 1024; k++) begin
            ram[k]     = $urandom;
            ref_mem[k] = ram[k];
        end
        ram[5]     = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        model_reset();

        // Reset with a store request held: nothing may be written.
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'd3; d_wdata = 32'hBAD0BAD0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_we",   mem_we,   0);
        check("rst_i_rvalid", i_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_i_rdata",  i_rdata,  0);
        check("rst_d_rdata",  d_rdata,  0);
        @(posedge clk); #1;
        idle();
        rst_n = 1'b1;
        cycle(gi, gd);
        check("rst_no_store", ram[3], ref_mem[3]);

        // Single fetch of address 5.
        i_req = 1'b1; i_addr = 10'd5;
        cycle(gi, gd);
        idle();
        check("rd5_rvalid", i_rvalid, 1);
        check("rd5_rdata",  i_rdata,  32'hDEADBEEF);
        cycle(gi, gd);

        // Store then fetch of the same address.
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'd7; d_wdata = 32'h12345678;
        cycle(gi, gd);
        check("st7_gnt", gd, 1);
        idle();
        i_req = 1'b1; i_addr = 10'd7;
        cycle(gi, gd);
        idle();
        check("st7_rdata", i_rdata, 32'h12345678);
        cycle(gi, gd);

        // Continuous conflict: D,D,D,I repeating.
        for (int k = 0; k < 12; k++) begin
            i_req = 1'b1; i_addr = AW'(k);
            d_req = 1'b1; d_we = 1'b0; d_addr = AW'(k + 32);
            cycle(gi, gd);
            check("starve_pattern", gi, (k % 4) == 3);
        end
        idle();
        cycle(gi, gd);

        // Back-to-back loads of 0..3: four consecutive rvalids in order.
        for (int k = 0; k < 4; k++) begin
            d_req = 1'b1; d_we = 1'b0; d_addr = AW'(k);
            cycle(gi, gd);
        end
        idle();
        for (int k = 0; k < 4; k++) cycle(gi, gd);

        // Reset right after a fetch grant: the response must be dropped.
        i_req = 1'b1; i_addr = 10'd9;
        @(negedge clk);
        check("rstg_gnt", i_gnt, 1);
        rst_n = 1'b0;
        i_req = 1'b0;
        @(posedge clk); #1;
        check("rstg_rvalid", i_rvalid, 0);
        @(negedge clk);
        check("rstg_rvalid2", i_rvalid, 0);
        check("rstg_rdata",   i_rdata,  0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        i_req = 1'b1; i_addr = 10'd9;
        cycle(gi, gd);
        idle();
        check("rstg_retry_rdata", i_rdata, ref_mem[9]);
        cycle(gi, gd);

        // Randomized traffic; requests are held until granted, with an
        // occasional legal withdrawal.
        for (int n = 0; n < 600; n++) begin
            if (!i_req || gi || $urandom_range(0, 19) == 0) begin
                i_req  = ($urandom_range(0, 99) < 60);
                i_addr = AW'($urandom_range(0, 15));
            end
            if (!d_req || gd || $urandom_range(0, 19) == 0) begin
                d_req   = ($urandom_range(0, 99) < 60);
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = AW'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
            cycle(gi, gd);
        end
        idle();
        repeat (2) cycle(gi, gd);
        for (int k = 0; k < 16; k++) check("final_ram", ram[k], ref_mem[k]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
